act_quant3: RTL and testbench
=============================

ACT_QUANT3 -- requirements
Module: act_quant3

Interface
REQ-001 SHALL have parameter VEC_LEN, default 3: elements per output vector.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, power of two: output FIFO entries.
REQ-003 SHALL have port clk, input, 1: clock, all state on rising edge.
REQ-004 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port s_valid, input, 1: upstream MAC result valid.
REQ-006 SHALL have port s_ready, output, 1: block can accept a result.
REQ-007 SHALL have port s_data, input, 16, signed: MAC accumulator result.
REQ-008 SHALL have port s_ovf, input, 1: upstream MAC overflow flag for s_data.
REQ-009 SHALL have port shift, input, 4, unsigned: requantization right-shift amount.
REQ-010 SHALL have port m_valid, output, 1: m_data valid.
REQ-011 SHALL have port m_ready, input, 1: downstream accepts m_data.
REQ-012 SHALL have port m_data, output, 8, signed: quantized activation.
REQ-013 SHALL have port m_last, output, 1: m_data is the final element of a vector.
REQ-014 SHALL have port sat, output, 1: sticky flag, some element saturated.

Function
REQ-015 SHALL accept an input only on a rising edge where s_valid=1 and s_ready=1; s_data, s_ovf and shift are sampled at that edge.
REQ-016 SHALL drive s_ready=1 exactly when FIFO occupancy < FIFO_DEPTH; a same-cycle pop does not raise s_ready when full.
REQ-017 SHALL round as follows: shift=0 passes s_data unchanged; shift>0 computes (s_data + 2^(shift-1)) arithmetic-right-shifted by shift, in 17-bit signed arithmetic with no intermediate wrap.
REQ-018 SHALL saturate the rounded value to the range [-128, 127].
REQ-019 SHALL, when s_ovf=1, output 127 if s_data[15]=0 and -128 if s_data[15]=1, ignoring rounding.
REQ-020 SHALL set sat on the accepting edge whenever REQ-018 clamps a value or REQ-019 applies; sat clears only on reset.
REQ-021 SHALL keep an element counter 0..VEC_LEN-1, increment it per accepted input, and wrap it to 0 after VEC_LEN-1.
REQ-022 SHALL store each result with last=1 when the counter equals VEC_LEN-1 at acceptance.
REQ-023 SHALL write the result and last flag into a FIFO_DEPTH-entry FIFO; m_data, m_last and m_valid come from the FIFO head.
REQ-024 SHALL give one-cycle latency: a word accepted into an empty FIFO at edge N has m_valid=1 in the cycle after edge N.
REQ-025 SHALL pop the head on a rising edge where m_valid=1 and m_ready=1; m_data and m_last are held stable while m_valid=1 and m_ready=0.
REQ-026 SHALL support push and pop on the same edge with occupancy unchanged, including at full (pop-side only, per REQ-016) and at occupancy 1.
REQ-027 SHALL deassert m_valid when occupancy is 0; m_data is don't-care then.
REQ-028 SHALL keep output order identical to input order; FIFO pointers wrap modulo FIFO_DEPTH.

Reset
REQ-029 SHALL, on reset=1 at a rising edge, clear occupancy, pointers, element counter and sat, with precedence over any same-edge push or pop.
REQ-030 SHALL reset outputs to m_valid=0, m_last=0, m_data=0, sat=0 and s_ready=1 (first cycle after reset).
REQ-031 SHALL discard all buffered data on a mid-vector reset; the next accepted input is element 0.

Configuration
REQ-032 SHALL, with macro ACT_QUANT3_RELU_EN defined, replace negative results after REQ-018/REQ-019 with 0; sat behaviour is unchanged (-128 from s_ovf still sets sat, output 0).
REQ-033 SHALL, without ACT_QUANT3_RELU_EN, pass signed results unmodified.

Verification
REQ-034 SHALL verify: no RELU, shift=0, inputs 5, -3, 200 with m_ready=1 -> outputs 5, -3, 127, m_last on the third only, sat=1 after the third.
REQ-035 SHALL verify: ACT_QUANT3_RELU_EN, same stimulus as REQ-034 -> outputs 5, 0, 127.
REQ-036 SHALL verify: shift=4, inputs 24, -24, 8, -9 -> outputs 2, -1, 1, -1, sat stays 0.
REQ-037 SHALL verify: m_ready=0, s_valid held with 6 inputs -> 4 accepted, s_ready=0 after the 4th; then m_ready=1 -> first 4 drain in order, remaining 2 accepted, and m_last is correct across the wrap.
REQ-038 SHALL verify: s_data=100 with s_ovf=1 -> 127 and sat=1; s_data=-100 with s_ovf=1 -> -128.
REQ-039 SHALL verify: reset after 2 of 3 elements with 2 words buffered -> m_valid=0, and the next 3 inputs yield m_last only on the 3rd.

Source files
------------

// File: rtl/act_quant3.sv
// act_quant3: rounds, clamps and optionally ReLUs MAC results to int8, tags vector ends, and buffers them in an output FIFO.
// Latency: one cycle from acceptance to m_valid. s_ready drops when the FIFO is full; a same-cycle pop does not reopen it.
// Optional feature: define ACT_QUANT3_RELU_EN to replace negative results with 0.
module act_quant3 #(
  parameter int VEC_LEN    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic signed [15:0] s_data,
  input  logic               s_ovf,
  input  logic        [3:0]  shift,
  output logic               m_valid,
  input  logic               m_ready,
  output logic signed [7:0]  m_data,
  output logic               m_last,
  output logic               sat
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_MAX = AW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(VEC_LEN - 1);

  logic signed [7:0]  mem_data [FIFO_DEPTH];
  logic               mem_last [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        count;
  logic [CW-1:0]      elem_cnt;

  logic               push, pop;
  logic signed [16:0] ext, rnd, rounded;
  logic signed [7:0]  q;
  logic               clamp_hit;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  assign s_ready = (count < DEPTH_C);
  assign m_valid = (count != '0);
  assign push    = s_valid && s_ready;
  assign pop     = m_valid && m_ready;
  assign m_data  = m_valid ? mem_data[rd_ptr] : '0;
  assign m_last  = m_valid ? mem_last[rd_ptr] : 1'b0;

  // 17-bit datapath: adding the half-LSB to a full-scale input cannot wrap
  always_comb begin
    ext       = {s_data[15], s_data};
    rnd       = '0;
    if (shift != 4'd0)
      rnd = 17'sd1 <<< (shift - 4'd1);
    rounded   = (ext + rnd) >>> shift;
    q         = rounded[7:0];
    clamp_hit = 1'b0;
    if (s_ovf) begin
      q         = s_data[15] ? 8'sh80 : 8'sh7F;
      clamp_hit = 1'b1;
    end else if (rounded > 17'sd127) begin
      q         = 8'sh7F;
      clamp_hit = 1'b1;
    end else if (rounded < -17'sd128) begin
      q         = 8'sh80;
      clamp_hit = 1'b1;
    end
`ifdef ACT_QUANT3_RELU_EN
    if (q < 8'sd0)
      q = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      elem_cnt <= '0;
      sat      <= 1'b0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= q;
        mem_last[wr_ptr] <= (elem_cnt == CNT_MAX);
        wr_ptr           <= ptr_inc(wr_ptr);
        elem_cnt         <= (elem_cnt == CNT_MAX) ? '0 : elem_cnt + 1'b1;
        if (clamp_hit)
          sat <= 1'b1;
      end
      if (pop)
        rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_act_quant3.sv
// Directed bench for act_quant3: vector table for the quantizer plus hand sequences for backpressure and reset.
module tb_act_quant3;

  logic               clk = 1'b0;
  logic               reset;
  logic               s_valid;
  logic               s_ready;
  logic signed [15:0] s_data;
  logic               s_ovf;
  logic        [3:0]  shift;
  logic               m_valid;
  logic               m_ready;
  logic signed [7:0]  m_data;
  logic               m_last;
  logic               sat;

  int nvec = 0;
  int nmis = 0;

  act_quant3 #(.VEC_LEN(3), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_ovf(s_ovf), .shift(shift),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .sat(sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                 rst;
    logic signed [15:0] d;
    bit                 ovf;
    logic [3:0]         sh;
    int                 exp_d;
    bit                 exp_last;
    bit                 exp_sat;
  } vec_t;

  vec_t tbl[$];

  function automatic int rx(input int x);
`ifdef ACT_QUANT3_RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  task automatic add(input bit r, input int d, input bit ovf, input int sh,
                     input int e, input bit l, input bit s);
    vec_t v;
    v.rst = r; v.d = 16'(d); v.ovf = ovf; v.sh = 4'(sh);
    v.exp_d = rx(e); v.exp_last = l; v.exp_sat = s;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic signed [31:0] got, input logic signed [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; s_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data",  m_data,  0);
    chk("rst_m_last",  m_last,  0);
    chk("rst_sat",     sat,     0);
    chk("rst_s_ready", s_ready, 1);
  endtask

  // Streams one word with m_ready=1; the previous word pops on the same edge.
  task automatic push_check(input int d, input bit ovf, input int sh,
                            input int e, input bit l, input bit s);
    s_data = 16'(d); s_ovf = ovf; shift = 4'(sh);
    s_valid = 1'b1; m_ready = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    chk("vec_m_valid", m_valid, 1);
    chk("vec_m_data",  m_data,  e);
    chk("vec_m_last",  m_last,  l);
    chk("vec_sat",     sat,     s);
    chk("vec_s_ready", s_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nin, nout, cyc;
    bit acc;

    reset = 1'b1; s_valid = 1'b0; s_data = '0; s_ovf = 1'b0; shift = '0; m_ready = 1'b0;

    // basic shift=0 with clamp on the third element
    add(1,     5, 0,  0,    5, 0, 0);
    add(0,    -3, 0,  0,   -3, 0, 0);
    add(0,   200, 0,  0,  127, 1, 1);
    // shift=4 rounding, no saturation
    add(1,    24, 0,  4,    2, 0, 0);
    add(0,   -24, 0,  4,   -1, 0, 0);
    add(0,     8, 0,  4,    1, 1, 0);
    add(0,    -9, 0,  4,   -1, 0, 0);
    // range edges and extreme shifts
    add(1,   127, 0,  0,  127, 0, 0);
    add(0,  -128, 0,  0, -128, 0, 0);
    add(0,     3, 0,  1,    2, 1, 0);
    add(0,    -3, 0,  1,   -1, 0, 0);
    add(0, 32767, 0, 15,    1, 0, 0);
    add(0,-32768, 0, 15,   -1, 1, 0);
    add(0,  2047, 0,  4,  127, 0, 1);
    add(0,  -129, 0,  0, -128, 0, 1);
    // upstream overflow overrides rounding
    add(1,   100, 1,  0,  127, 0, 1);
    add(0,  -100, 1,  0, -128, 0, 1);
    add(0,    16, 1,  4,  127, 1, 1);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      push_check(int'(tbl[i].d), tbl[i].ovf, int'(tbl[i].sh),
                 tbl[i].exp_d, tbl[i].exp_last, tbl[i].exp_sat);
    end
    @(posedge clk); #1;
    chk("drain_empty", m_valid, 0);

    // Backpressure: fill to full, hold, then drain while the last two enter
    do_reset();
    m_ready = 1'b0; shift = '0; s_ovf = 1'b0;
    nin = 0; s_data = 16'(10); s_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      nin++;
      s_data = 16'(10 + nin);
      chk("fill_s_ready", s_ready, (nin < 4) ? 1 : 0);
    end
    chk("full_m_valid", m_valid, 1);
    chk("full_m_data",  m_data, 10);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk("hold_s_ready", s_ready, 0);
      chk("hold_m_data",  m_data, 10);
      chk("hold_m_last",  m_last, 0);
    end
    chk("hold_nin", nin, 4);
    m_ready = 1'b1;
    nout = 0; cyc = 0;
    while (nout < 6 && cyc < 40) begin
      if (m_valid) begin
        chk("drain_m_data", m_data, 10 + nout);
        chk("drain_m_last", m_last, (nout % 3 == 2) ? 1 : 0);
        nout++;
      end
      if (nout < 6) begin
        acc = s_valid && s_ready;
        @(posedge clk); #1;
        cyc++;
        if (acc) begin
          nin++;
          if (nin == 6) s_valid = 1'b0;
          else          s_data = 16'(10 + nin);
        end
      end
    end
    chk("drain_count", nout, 6);
    chk("drain_accepted", nin, 6);
    s_valid = 1'b0;
    @(posedge clk); #1;
    chk("drain_done_m_valid", m_valid, 0);

    // Mid-vector reset with two words buffered; reset wins over a same-edge push
    do_reset();
    m_ready = 1'b0; shift = '0; s_ovf = 1'b0;
    s_valid = 1'b1;
    s_data = 16'(20); @(posedge clk); #1;
    s_data = 16'(21); @(posedge clk); #1;
    chk("pre_rst_m_valid", m_valid, 1);
    chk("pre_rst_m_data",  m_data, 20);
    s_data = 16'(22);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; s_valid = 1'b0;
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_s_ready", s_ready, 1);
    push_check(30, 0, 0, 30, 0, 0);
    push_check(31, 0, 0, 31, 0, 0);
    push_check(32, 0, 0, 32, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
